mainfsm_wait: RTL and testbench
===============================

Name: mainfsm_wait

Overview:
- Parametrised successor to the multicycle CPU main control FSM.
- Adds two handshakes to the fixed-latency control path: a memory wait-state handshake (mem_ready) and a variable-latency multiply unit (ex_start/ex_done).
- Adds a wait timeout with a sticky fault state and illegal-opcode detection.
- Sits between the instruction decoder and the datapath; drives the same 13-bit control vector.

Parameters:
- WAIT_TIMEOUT, 64: maximum cycles spent in any wait state before entering FAULT. 0 disables the timeout.
- TMO_W, 7: timeout counter width. Must satisfy 2^TMO_W > WAIT_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction op field.
- Funct  in  6  instruction funct field. Bit 5 = immediate; bit 0 = load (1) or store (0).
- is_mul  in  1  decoder flag: the Op=11 instruction is a multiply.
- mem_ready  in  1  memory completes the current access this cycle.
- ex_done  in  1  multiply unit result valid; a one-cycle pulse is sufficient.
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- ex_start  out  1  one-cycle multiply launch pulse.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- fault  out  1  sticky; set on timeout.
- state_dbg  out  4  current state code.

Behaviour:
- Control vector order, 13 bits: {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10, EXMUL=11, EXWAIT=12, FAULT=13.
- Reset (reset=0, asynchronous):
  - state=FETCH, timeout counter=0, fault=0.
  - All outputs take FETCH values with mem_ready gating applied; ex_start=0, illegal=0.
- FETCH: 1000101001100.
  - NextPC and IRWrite are ANDed with mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: 0000001001100. Next state by Op:
  - Op=00: EXECUTEI if Funct[5]=1, else EXECUTER.
  - Op=01: MEMADR.
  - Op=10: BRANCH.
  - Op=11: EXMUL if is_mul=1, else UNKNOWN.
- EXECUTER (0000000000001) and EXECUTEI (0000000000011) go to ALUWB.
- ALUWB: 0001000000000 then FETCH.
- MEMADR: 0000000000010. Go to MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: 0000010000000. Hold until mem_ready=1, then MEMWB.
- MEMWB: 0001000100000 then FETCH.
- MEMWRITE: 0010010000000.
  - MemW stays asserted every cycle until mem_ready=1, then FETCH.
  - The write completes in exactly the mem_ready cycle.
- BRANCH: 0100001000010 then FETCH.
- EXMUL: controls 0000000000001, ex_start=1 for exactly this cycle, then EXWAIT.
- EXWAIT: controls 0000000000000.
  - Hold until ex_done=1, then ALUWB.
  - The ALUWB that follows EXWAIT drives 0001001100001 (RegW=1, ResultSrc=11 selects multiplier result).
  - ex_done arriving in the EXMUL cycle itself is ignored; only EXWAIT samples ex_done.
- UNKNOWN: all controls 0, illegal=1 for one cycle, then FETCH. No register or memory write occurs.
- Timeout (wait states FETCH, MEMREAD, MEMWRITE, EXWAIT):
  - Counter clears on entry to any wait state and increments each cycle the wait condition is unmet.
  - If WAIT_TIMEOUT>0 and counter==WAIT_TIMEOUT-1 with the condition still unmet, go to FAULT. WAIT_TIMEOUT cycles of waiting are therefore allowed.
  - If the condition is met in the same cycle the limit is reached, completion wins.
- FAULT: all controls 0, fault=1. Absorbing; exits only through reset.
- Counter saturates and never wraps.
- Unused state codes (14, 15) go to FAULT.

Optional Feature:
- MAINFSM_PERF_EN defined:
  - Adds outputs instr_count[31:0] and stall_count[31:0], both reset to 0.
  - instr_count increments on every FETCH-to-DECODE transition.
  - stall_count increments each cycle spent in a wait state with its condition unmet.
  - Both wrap modulo 2^32.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ADD register (Op=00, Funct[5]=0), mem_ready tied 1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH in 4 cycles; RegW=1 only in ALUWB.
- LDR (Op=01, Funct[0]=1), mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; MEMWB asserts RegW=1, ResultSrc=01.
- STR with mem_ready delayed 2 cycles -> MemW=1 for exactly 3 consecutive cycles, then FETCH.
- MUL (Op=11, is_mul=1), ex_done after 5 EXWAIT cycles -> ex_start single pulse in EXMUL; ALUWB drives ResultSrc=11, RegW=1.
- Op=11, is_mul=0 -> UNKNOWN for 1 cycle, illegal pulse, no RegW/MemW, next state FETCH.
- WAIT_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 cycles, fault=1 held; reset pulse low returns to FETCH with fault=0.

Source files
------------

// File: rtl/mainfsm_wait_if.sv
// Decoder/datapath-side bundle for the mainfsm_wait control FSM.
// Counter outputs exist only when MAINFSM_PERF_EN is defined.
interface mainfsm_wait_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       is_mul;
  logic       mem_ready;
  logic       ex_done;

  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ex_start;
  logic       illegal;
  logic       fault;
  logic [3:0] state_dbg;
`ifdef MAINFSM_PERF_EN
  logic [31:0] instr_count;
  logic [31:0] stall_count;
`endif

  // FSM side
  modport master (
`ifdef MAINFSM_PERF_EN
    output instr_count, output stall_count,
`endif
    input  Op, Funct, is_mul, mem_ready, ex_done,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    output ALUSrcA, ALUSrcB, ResultSrc,
    output ex_start, illegal, fault, state_dbg
  );

  // Decoder/datapath side
  modport slave (
`ifdef MAINFSM_PERF_EN
    input  instr_count, input stall_count,
`endif
    output Op, Funct, is_mul, mem_ready, ex_done,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
    input  ALUSrcA, ALUSrcB, ResultSrc,
    input  ex_start, illegal, fault, state_dbg
  );
endinterface

// File: rtl/mainfsm_wait.sv
// Multicycle CPU main control FSM with memory wait states, variable-latency
// multiply handshake, wait timeout/fault. Optional counters: MAINFSM_PERF_EN.
module mainfsm_wait #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int TMO_W        = 7
) (
  input  logic            clk,
  input  logic            reset,
  mainfsm_wait_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10,
    S_EXMUL    = 4'd11,
    S_EXWAIT   = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  // {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  localparam logic [12:0] C_FETCH     = 13'b1000101001100;
  localparam logic [12:0] C_DECODE    = 13'b0000001001100;
  localparam logic [12:0] C_EXECUTER  = 13'b0000000000001;
  localparam logic [12:0] C_EXECUTEI  = 13'b0000000000011;
  localparam logic [12:0] C_ALUWB     = 13'b0001000000000;
  localparam logic [12:0] C_ALUWB_MUL = 13'b0001001100001;
  localparam logic [12:0] C_MEMADR    = 13'b0000000000010;
  localparam logic [12:0] C_MEMREAD   = 13'b0000010000000;
  localparam logic [12:0] C_MEMWB     = 13'b0001000100000;
  localparam logic [12:0] C_MEMWRITE  = 13'b0010010000000;
  localparam logic [12:0] C_BRANCH    = 13'b0100001000010;
  localparam logic [12:0] C_EXMUL     = 13'b0000000000001;

  localparam logic             TMO_EN   = (WAIT_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(WAIT_TIMEOUT - 1) : '0;

  state_t           state_reg, state_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             mulwb_reg, mulwb_next;
  logic             wait_unmet;
  logic             tmo_hit;
  logic [12:0]      ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      tmo_reg   <= '0;
      mulwb_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      mulwb_reg <= mulwb_next;
    end
  end

  always_comb begin
    wait_unmet = 1'b0;
    case (state_reg)
      S_FETCH, S_MEMREAD, S_MEMWRITE: wait_unmet = !bus.mem_ready;
      S_EXWAIT:                       wait_unmet = !bus.ex_done;
      default:                        wait_unmet = 1'b0;
    endcase
    tmo_hit = TMO_EN && wait_unmet && (tmo_reg == TMO_LAST);
  end

  always_comb begin
    state_next = state_reg;
    mulwb_next = 1'b0;
    case (state_reg)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
                  else if (tmo_hit)  state_next = S_FAULT;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = bus.is_mul ? S_EXMUL : S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
                  else if (tmo_hit)  state_next = S_FAULT;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
                  else if (tmo_hit)  state_next = S_FAULT;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_UNKNOWN:  state_next = S_FETCH;
      S_EXMUL:    state_next = S_EXWAIT;
      S_EXWAIT: begin
        if (bus.ex_done) begin
          state_next = S_ALUWB;
          mulwb_next = 1'b1;
        end else if (tmo_hit) begin
          state_next = S_FAULT;
        end
      end
      S_FAULT:    state_next = S_FAULT;
      default:    state_next = S_FAULT;
    endcase
  end

  // Any state change clears the counter, so every wait state starts from zero.
  always_comb begin
    tmo_next = tmo_reg;
    if (state_next != state_reg)
      tmo_next = '0;
    else if (wait_unmet && (tmo_reg != '1))
      tmo_next = tmo_reg + 1'b1;
  end

  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl     = C_FETCH;
        ctrl[12] = bus.mem_ready;
        ctrl[8]  = bus.mem_ready;
      end
      S_DECODE:   ctrl = C_DECODE;
      S_MEMADR:   ctrl = C_MEMADR;
      S_MEMREAD:  ctrl = C_MEMREAD;
      S_MEMWB:    ctrl = C_MEMWB;
      S_MEMWRITE: ctrl = C_MEMWRITE;
      S_EXECUTER: ctrl = C_EXECUTER;
      S_EXECUTEI: ctrl = C_EXECUTEI;
      S_ALUWB:    ctrl = mulwb_reg ? C_ALUWB_MUL : C_ALUWB;
      S_BRANCH:   ctrl = C_BRANCH;
      S_EXMUL:    ctrl = C_EXMUL;
      default:    ctrl = '0;
    endcase
  end

  assign {bus.NextPC, bus.Branch, bus.MemW, bus.RegW, bus.IRWrite, bus.AdrSrc,
          bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} = ctrl;
  assign bus.ex_start  = (state_reg == S_EXMUL);
  assign bus.illegal   = (state_reg == S_UNKNOWN);
  assign bus.fault     = (state_reg == S_FAULT);
  assign bus.state_dbg = state_reg;

`ifdef MAINFSM_PERF_EN
  logic [31:0] instr_count_reg;
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if ((state_reg == S_FETCH) && bus.mem_ready)
        instr_count_reg <= instr_count_reg + 32'd1;
      if (wait_unmet)
        stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign bus.instr_count = instr_count_reg;
  assign bus.stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_mainfsm_wait.sv
// Directed bench for mainfsm_wait: cycle-by-cycle vector table on a default
// instance plus hand-written timeout/reset sequences on a WAIT_TIMEOUT=4 instance.
module tb_mainfsm_wait;

  localparam logic [12:0] C_FETCH     = 13'b1000101001100;
  localparam logic [12:0] C_FETCH_G   = 13'b0000001001100;
  localparam logic [12:0] C_DEC       = 13'b0000001001100;
  localparam logic [12:0] C_EXR       = 13'b0000000000001;
  localparam logic [12:0] C_EXI       = 13'b0000000000011;
  localparam logic [12:0] C_ALUWB     = 13'b0001000000000;
  localparam logic [12:0] C_ALUWB_MUL = 13'b0001001100001;
  localparam logic [12:0] C_MEMADR    = 13'b0000000000010;
  localparam logic [12:0] C_MEMRD     = 13'b0000010000000;
  localparam logic [12:0] C_MEMWB     = 13'b0001000100000;
  localparam logic [12:0] C_MEMWR     = 13'b0010010000000;
  localparam logic [12:0] C_BR        = 13'b0100001000010;
  localparam logic [12:0] C_EXMUL     = 13'b0000000000001;
  localparam logic [12:0] C_ZERO      = 13'b0000000000000;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        mul;
    logic        mr;
    logic        ed;
    logic [3:0]  st;
    logic [12:0] c;
    logic        es;
    logic        il;
  } vec_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [64];
  int   nvec = 0;

  always #5 clk = ~clk;

  mainfsm_wait_if bus_a ();
  mainfsm_wait_if bus_b ();

  mainfsm_wait u_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  mainfsm_wait #(.WAIT_TIMEOUT(4), .TMO_W(3)) u_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  logic [12:0] ctrl_a, ctrl_b;
  assign ctrl_a = {bus_a.NextPC, bus_a.Branch, bus_a.MemW, bus_a.RegW, bus_a.IRWrite,
                   bus_a.AdrSrc, bus_a.ResultSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp};
  assign ctrl_b = {bus_b.NextPC, bus_b.Branch, bus_b.MemW, bus_b.RegW, bus_b.IRWrite,
                   bus_b.AdrSrc, bus_b.ResultSrc, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int op, input int fn, input int mul, input int mr, input int ed,
                     input int st, input logic [12:0] c, input int es, input int il);
    vecs[nvec].op  = 2'(op);
    vecs[nvec].fn  = 6'(fn);
    vecs[nvec].mul = 1'(mul);
    vecs[nvec].mr  = 1'(mr);
    vecs[nvec].ed  = 1'(ed);
    vecs[nvec].st  = 4'(st);
    vecs[nvec].c   = c;
    vecs[nvec].es  = 1'(es);
    vecs[nvec].il  = 1'(il);
    nvec++;
  endtask

  task automatic check_b(input string name, input int st, input logic [12:0] c, input int flt);
    check({name, ".state"}, 32'(bus_b.state_dbg), 32'(st));
    check({name, ".ctrl"},  32'(ctrl_b),          32'(c));
    check({name, ".fault"}, 32'(bus_b.fault),     32'(flt));
    $display("[TB] B %s state=%0d ctrl=%b fault=%0d", name, bus_b.state_dbg, ctrl_b, bus_b.fault);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ADD register
    add(0, 0, 0, 1, 0, 0, C_FETCH, 0, 0);
    add(0, 0, 0, 1, 0, 1, C_DEC,   0, 0);
    add(0, 0, 0, 1, 0, 6, C_EXR,   0, 0);
    add(0, 0, 0, 1, 0, 8, C_ALUWB, 0, 0);
    // LDR, three memory wait cycles
    add(1, 1, 0, 1, 0, 0, C_FETCH,  0, 0);
    add(1, 1, 0, 1, 0, 1, C_DEC,    0, 0);
    add(1, 1, 0, 1, 0, 2, C_MEMADR, 0, 0);
    add(1, 1, 0, 0, 0, 3, C_MEMRD,  0, 0);
    add(1, 1, 0, 0, 0, 3, C_MEMRD,  0, 0);
    add(1, 1, 0, 0, 0, 3, C_MEMRD,  0, 0);
    add(1, 1, 0, 1, 0, 3, C_MEMRD,  0, 0);
    add(1, 1, 0, 1, 0, 4, C_MEMWB,  0, 0);
    // STR, MemW held three cycles
    add(1, 0, 0, 1, 0, 0, C_FETCH,  0, 0);
    add(1, 0, 0, 1, 0, 1, C_DEC,    0, 0);
    add(1, 0, 0, 1, 0, 2, C_MEMADR, 0, 0);
    add(1, 0, 0, 0, 0, 5, C_MEMWR,  0, 0);
    add(1, 0, 0, 0, 0, 5, C_MEMWR,  0, 0);
    add(1, 0, 0, 1, 0, 5, C_MEMWR,  0, 0);
    // MUL: ex_done in EXMUL is ignored, then 5 idle EXWAIT cycles
    add(3, 0, 1, 1, 0, 0,  C_FETCH,     0, 0);
    add(3, 0, 1, 1, 0, 1,  C_DEC,       0, 0);
    add(3, 0, 1, 1, 1, 11, C_EXMUL,     1, 0);
    add(3, 0, 1, 1, 0, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 0, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 0, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 0, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 0, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 1, 12, C_ZERO,      0, 0);
    add(3, 0, 1, 1, 0, 8,  C_ALUWB_MUL, 0, 0);
    // Op=11 without is_mul
    add(3, 0, 0, 1, 0, 0,  C_FETCH, 0, 0);
    add(3, 0, 0, 1, 0, 1,  C_DEC,   0, 0);
    add(3, 0, 0, 1, 0, 10, C_ZERO,  0, 1);
    // Gated FETCH stall, then BRANCH
    add(2, 0, 0, 0, 0, 0, C_FETCH_G, 0, 0);
    add(2, 0, 0, 1, 0, 0, C_FETCH,   0, 0);
    add(2, 0, 0, 1, 0, 1, C_DEC,     0, 0);
    add(2, 0, 0, 1, 0, 9, C_BR,      0, 0);
    // EXECUTEI; ALUWB must not keep the multiply ResultSrc
    add(0, 32, 0, 1, 0, 0, C_FETCH, 0, 0);
    add(0, 32, 0, 1, 0, 1, C_DEC,   0, 0);
    add(0, 32, 0, 1, 0, 7, C_EXI,   0, 0);
    add(0, 32, 0, 1, 0, 8, C_ALUWB, 0, 0);
    add(0, 0,  0, 1, 0, 0, C_FETCH, 0, 0);

    reset_a = 1'b0;
    reset_b = 1'b0;
    {bus_a.Op, bus_a.Funct, bus_a.is_mul, bus_a.mem_ready, bus_a.ex_done} = '0;
    {bus_b.Op, bus_b.Funct, bus_b.is_mul, bus_b.mem_ready, bus_b.ex_done} = '0;

    repeat (3) next_cycle();
    @(negedge clk);
    check("rst.state",    32'(bus_a.state_dbg), 32'd0);
    check("rst.ctrl",     32'(ctrl_a),          32'(C_FETCH_G));
    check("rst.ex_start", 32'(bus_a.ex_start),  32'd0);
    check("rst.illegal",  32'(bus_a.illegal),   32'd0);
    check("rst.fault",    32'(bus_a.fault),     32'd0);
    $display("[TB] reset state=%0d ctrl=%b", bus_a.state_dbg, ctrl_a);

    next_cycle();
    reset_a = 1'b1;
    for (int i = 0; i < nvec; i++) begin
      bus_a.Op        = vecs[i].op;
      bus_a.Funct     = vecs[i].fn;
      bus_a.is_mul    = vecs[i].mul;
      bus_a.mem_ready = vecs[i].mr;
      bus_a.ex_done   = vecs[i].ed;
      @(negedge clk);
      check($sformatf("v%0d.state", i),    32'(bus_a.state_dbg), 32'(vecs[i].st));
      check($sformatf("v%0d.ctrl", i),     32'(ctrl_a),          32'(vecs[i].c));
      check($sformatf("v%0d.ex_start", i), 32'(bus_a.ex_start),  32'(vecs[i].es));
      check($sformatf("v%0d.illegal", i),  32'(bus_a.illegal),   32'(vecs[i].il));
      check($sformatf("v%0d.fault", i),    32'(bus_a.fault),     32'd0);
      $display("[TB] A row %0d state=%0d ctrl=%b ex_start=%0d illegal=%0d",
               i, bus_a.state_dbg, ctrl_a, bus_a.ex_start, bus_a.illegal);
      next_cycle();
    end

    // Timeout instance: completion at the limit wins
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_b($sformatf("fetch_wait%0d", i), 0, C_FETCH_G, 0);
      next_cycle();
    end
    bus_b.mem_ready = 1'b1;
    @(negedge clk);
    check_b("fetch_limit_met", 0, C_FETCH, 0);
    next_cycle();
    @(negedge clk);
    check_b("decode", 1, C_DEC, 0);
    next_cycle();
    @(negedge clk);
    check_b("exr", 6, C_EXR, 0);
    next_cycle();
    @(negedge clk);
    check_b("aluwb", 8, C_ALUWB, 0);
    next_cycle();

    // Counter restarts on FETCH entry: exactly four waiting cycles allowed
    bus_b.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_b($sformatf("tmo_wait%0d", i), 0, C_FETCH_G, 0);
      next_cycle();
    end
    @(negedge clk);
    check_b("fault_entry", 13, C_ZERO, 1);
    next_cycle();
    bus_b.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_b($sformatf("fault_hold%0d", i), 13, C_ZERO, 1);
      next_cycle();
    end

    // Asynchronous reset mid-cycle
    #2;
    reset_b = 1'b0;
    #1;
    check_b("async_reset", 0, C_FETCH, 0);
    next_cycle();
    reset_b = 1'b1;
    @(negedge clk);
    check_b("post_reset_fetch", 0, C_FETCH, 0);
    next_cycle();
    @(negedge clk);
    check_b("post_reset_decode", 1, C_DEC, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
